cal_init_mr_arbiter: RTL and testbench

- Shares the single cal_init mode-register write channel of the DDR init/calibration engine between up to 8 training requesters, for example the DDR4 VREFDQ sequencer, write-levelling and gate training.
- Arbitration is round-robin. The winner's command payload is latched and held stable until the engine acknowledges it.
- The acknowledge is routed back to the winner only.
- An ack watchdog prevents a missing ack from hanging training.

---
 rtl/cal_init_mr_arbiter.sv | 177 +++++++++++++++++
 tb/tb_cal_init_mr_arbiter.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cal_init_mr_arbiter.sv
// Round-robin arbiter sharing the cal_init mode-register write channel between
// training requesters, with a latched payload, routed ack and an ack watchdog.
module cal_init_mr_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ACK_TIMEOUT = 1023,
  parameter int unsigned HOLDOFF     = 2
) (
  input  logic                    SCLK,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req_w_req,
  input  logic [NUM_REQ*8-1:0]    req_mr_addr,
  input  logic [NUM_REQ*18-1:0]   req_mr_wr_data,
  input  logic [NUM_REQ*18-1:0]   req_mr_wr_mask,
  input  logic [NUM_REQ*2-1:0]    req_cs,
  output logic [NUM_REQ-1:0]      req_ack,
  output logic                    cal_init_mr_w_req,
  output logic [7:0]              cal_init_mr_addr,
  output logic [17:0]             cal_init_mr_wr_data,
  output logic [17:0]             cal_init_mr_wr_mask,
  output logic [1:0]              cal_init_cs,
  input  logic                    cal_init_ack,
  output logic [2:0]              grant_id,
  output logic                    busy,
  output logic                    timeout_err,
  output logic                    spurious_ack
);

  localparam int unsigned WD_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int unsigned HO_N = (HOLDOFF > 0) ? HOLDOFF : 1;
  localparam int unsigned HO_W = (HO_N > 1) ? $clog2(HO_N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RELEASE
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          ptr_q, ptr_d;
  logic [2:0]          grant_q, grant_d;
  logic                wreq_q, wreq_d;
  logic [7:0]          addr_q, addr_d;
  logic [17:0]         data_q, data_d;
  logic [17:0]         mask_q, mask_d;
  logic [1:0]          cs_q, cs_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                busy_q, busy_d;
  logic                tmo_q, tmo_d;
  logic                spur_q, spur_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic [HO_W-1:0]     ho_q, ho_d;

  logic                found;
  logic [2:0]          win;
  int unsigned         win_idx;
  int unsigned         idx;
  logic                tmo_hit;

  // First set request at or above the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    found   = 1'b0;
    win_idx = 0;
    idx     = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(ptr_q) + i) % NUM_REQ;
      if (!found && ((req_w_req >> idx) & NUM_REQ'(1)) != '0) begin
        found   = 1'b1;
        win_idx = idx;
      end
    end
    win = 3'(win_idx);
  end

  assign tmo_hit = (ACK_TIMEOUT != 0) && (wd_q == WD_W'(ACK_TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    wreq_d  = wreq_q;
    addr_d  = addr_q;
    data_d  = data_q;
    mask_d  = mask_q;
    cs_d    = cs_q;
    ack_d   = '0;
    busy_d  = busy_q;
    tmo_d   = tmo_q;
    spur_d  = spur_q;
    wd_d    = wd_q;
    ho_d    = ho_q;
    unique case (state_q)
      S_IDLE: begin
        if (cal_init_ack) spur_d = 1'b1;
        if (found) begin
          state_d = S_ISSUE;
          grant_d = win;
          wreq_d  = 1'b1;
          busy_d  = 1'b1;
          addr_d  = 8'(req_mr_addr >> (8 * win_idx));
          data_d  = 18'(req_mr_wr_data >> (18 * win_idx));
          mask_d  = 18'(req_mr_wr_mask >> (18 * win_idx));
          cs_d    = 2'(req_cs >> (2 * win_idx));
          wd_d    = '0;
        end
      end
      S_ISSUE: begin
        // An ack coinciding with watchdog expiry counts as a normal completion.
        if (cal_init_ack || tmo_hit) begin
          state_d = S_RELEASE;
          wreq_d  = 1'b0;
          ack_d   = NUM_REQ'(1) << grant_q;
          ptr_d   = (grant_q == 3'(NUM_REQ - 1)) ? '0 : grant_q + 3'd1;
          ho_d    = '0;
          if (!cal_init_ack) tmo_d = 1'b1;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_RELEASE: begin
        if (cal_init_ack) spur_d = 1'b1;
        if (ho_q == HO_W'(HO_N - 1)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          ho_d = ho_q + HO_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge SCLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      wreq_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      cs_q    <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
      spur_q  <= 1'b0;
      wd_q    <= '0;
      ho_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      wreq_q  <= wreq_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      cs_q    <= cs_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
      spur_q  <= spur_d;
      wd_q    <= wd_d;
      ho_q    <= ho_d;
    end
  end

  assign req_ack             = ack_q;
  assign cal_init_mr_w_req   = wreq_q;
  assign cal_init_mr_addr    = addr_q;
  assign cal_init_mr_wr_data = data_q;
  assign cal_init_mr_wr_mask = mask_q;
  assign cal_init_cs         = cs_q;
  assign grant_id            = grant_q;
  assign busy                = busy_q;
  assign timeout_err         = tmo_q;
  assign spurious_ack        = spur_q;

endmodule

// File: tb/tb_cal_init_mr_arbiter.sv
// Self-checking bench for cal_init_mr_arbiter: grant scoreboard plus per-scenario tasks.
`timescale 1ns/1ps
module tb_cal_init_mr_arbiter;

  localparam int unsigned N = 4;

  logic            SCLK = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    req_w_req = '0;
  logic [N*8-1:0]  req_mr_addr = '0;
  logic [N*18-1:0] req_mr_wr_data = '0;
  logic [N*18-1:0] req_mr_wr_mask = '0;
  logic [N*2-1:0]  req_cs = '0;
  logic [N-1:0]    req_ack;
  logic            cal_init_mr_w_req;
  logic [7:0]      cal_init_mr_addr;
  logic [17:0]     cal_init_mr_wr_data;
  logic [17:0]     cal_init_mr_wr_mask;
  logic [1:0]      cal_init_cs;
  logic            cal_init_ack = 1'b0;
  logic [2:0]      grant_id;
  logic            busy;
  logic            timeout_err;
  logic            spurious_ack;

  cal_init_mr_arbiter #(
    .NUM_REQ    (N),
    .ACK_TIMEOUT(16),
    .HOLDOFF    (2)
  ) dut (
    .SCLK               (SCLK),
    .reset_n            (reset_n),
    .req_w_req          (req_w_req),
    .req_mr_addr        (req_mr_addr),
    .req_mr_wr_data     (req_mr_wr_data),
    .req_mr_wr_mask     (req_mr_wr_mask),
    .req_cs             (req_cs),
    .req_ack            (req_ack),
    .cal_init_mr_w_req  (cal_init_mr_w_req),
    .cal_init_mr_addr   (cal_init_mr_addr),
    .cal_init_mr_wr_data(cal_init_mr_wr_data),
    .cal_init_mr_wr_mask(cal_init_mr_wr_mask),
    .cal_init_cs        (cal_init_cs),
    .cal_init_ack       (cal_init_ack),
    .grant_id           (grant_id),
    .busy               (busy),
    .timeout_err        (timeout_err),
    .spurious_ack       (spurious_ack)
  );

  always #5 SCLK = ~SCLK;

  typedef struct packed {
    logic [2:0]  id;
    logic [7:0]  addr;
    logic [17:0] data;
    logic [17:0] mask;
    logic [1:0]  cs;
  } exp_t;

  exp_t sb_q[$];
  exp_t cur = '0;
  logic prev_wreq = 1'b0;
  int   errors = 0;
  int   checks = 0;

  logic [N+1+8+18+18+2+3+3-1:0] all_outs;
  assign all_outs = {req_ack, cal_init_mr_w_req, cal_init_mr_addr, cal_init_mr_wr_data,
                     cal_init_mr_wr_mask, cal_init_cs, grant_id, busy, timeout_err, spurious_ack};

  function automatic exp_t mk_exp(input int unsigned id, input logic [7:0] a,
                                  input logic [17:0] d, input logic [17:0] m, input logic [1:0] c);
    exp_t e;
    e.id = 3'(id); e.addr = a; e.data = d; e.mask = m; e.cs = c;
    return e;
  endfunction

  task automatic drive_req(input int unsigned i, input logic [7:0] a, input logic [17:0] d,
                           input logic [17:0] m, input logic [1:0] c);
    req_mr_addr[i*8 +: 8]     = a;
    req_mr_wr_data[i*18 +: 18] = d;
    req_mr_wr_mask[i*18 +: 18] = m;
    req_cs[i*2 +: 2]          = c;
  endtask

  task automatic do_reset;
    reset_n      = 1'b0;
    req_w_req    = '0;
    cal_init_ack = 1'b0;
    repeat (3) @(negedge SCLK);
    reset_n = 1'b1;
    @(negedge SCLK);
  endtask

  // Grant monitor: pops the scoreboard on each new grant and holds the payload to it until the ack.
  always @(negedge SCLK) begin
    if (!reset_n) begin
      prev_wreq = 1'b0;
    end else begin
      if (cal_init_mr_w_req && !prev_wreq) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL grant_unexpected: got grant_id=%0d, required no grant", grant_id);
        end else begin
          cur = sb_q.pop_front();
          if ({grant_id, cal_init_mr_addr, cal_init_mr_wr_data, cal_init_mr_wr_mask, cal_init_cs} !== cur) begin
            errors++;
            $display("FAIL grant_payload: got %h, required %h",
                     {grant_id, cal_init_mr_addr, cal_init_mr_wr_data, cal_init_mr_wr_mask, cal_init_cs}, cur);
          end
        end
      end else if (cal_init_mr_w_req) begin
        checks++;
        if ({grant_id, cal_init_mr_addr, cal_init_mr_wr_data, cal_init_mr_wr_mask, cal_init_cs} !== cur) begin
          errors++;
          $display("FAIL payload_hold: got %h, required %h",
                   {grant_id, cal_init_mr_addr, cal_init_mr_wr_data, cal_init_mr_wr_mask, cal_init_cs}, cur);
        end
      end
      if (req_ack !== '0) begin
        checks++;
        if (req_ack !== (4'b0001 << cur.id) || !prev_wreq || cal_init_mr_w_req) begin
          errors++;
          $display("FAIL ack_route: got req_ack=%b prev_wreq=%b w_req=%b, required req_ack=%b after ISSUE",
                   req_ack, prev_wreq, cal_init_mr_w_req, 4'b0001 << cur.id);
        end
      end
      prev_wreq = cal_init_mr_w_req;
    end
  end

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(negedge SCLK);
    checks++;
    if (all_outs !== '0) begin
      errors++;
      $display("FAIL reset_state: got %h, required 0", all_outs);
    end
    reset_n = 1'b1;
    @(negedge SCLK);
  endtask

  task automatic test_round_robin;
    int n;
    for (int unsigned i = 0; i < N; i++)
      drive_req(i, 8'(16 + i), 18'(4096 + 273 * i), 18'(262143 >> i), 2'(i));
    for (int k = 0; k < 6; k++) begin
      int unsigned id = 32'(k) % N;
      sb_q.push_back(mk_exp(id, 8'(16 + id), 18'(4096 + 273 * id), 18'(262143 >> id), 2'(id)));
    end
    req_w_req = '1;
    for (int k = 0; k < 6; k++) begin
      int unsigned id = 32'(k) % N;
      n = 0;
      while (!cal_init_mr_w_req && n < 20) begin
        @(negedge SCLK);
        n++;
      end
      checks++;
      if (cal_init_mr_w_req !== 1'b1 || grant_id !== 3'(id)) begin
        errors++;
        $display("FAIL rr_order[%0d]: got w_req=%b grant_id=%0d, required w_req=1 grant_id=%0d",
                 k, cal_init_mr_w_req, grant_id, id);
      end
      @(negedge SCLK);
      cal_init_ack = 1'b1;
      @(negedge SCLK);
      cal_init_ack = 1'b0;
      checks++;
      if (req_ack !== 4'(1 << id)) begin
        errors++;
        $display("FAIL rr_ack[%0d]: got %b, required %b", k, req_ack, 4'(1 << id));
      end
      if (k == 5) req_w_req = '0;
    end
    repeat (3) @(negedge SCLK);
    checks++;
    if (busy !== 1'b0 || cal_init_mr_w_req !== 1'b0) begin
      errors++;
      $display("FAIL rr_idle: got busy=%b w_req=%b, required 0 0", busy, cal_init_mr_w_req);
    end
  endtask

  task automatic test_single;
    sb_q.push_back(mk_exp(2, 8'h06, 18'h00080, 18'h3FF00, 2'b01));
    drive_req(2, 8'h06, 18'h00080, 18'h3FF00, 2'b01);
    req_w_req = 4'b0100;
    @(negedge SCLK);
    checks++;
    if (cal_init_mr_w_req !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_latency: got w_req=%b busy=%b, required 1 1", cal_init_mr_w_req, busy);
    end
    repeat (4) @(negedge SCLK);
    cal_init_ack = 1'b1;
    checks++;
    if (req_ack !== 4'b0000 || cal_init_mr_w_req !== 1'b1) begin
      errors++;
      $display("FAIL single_pre_ack: got req_ack=%b w_req=%b, required 0000 1", req_ack, cal_init_mr_w_req);
    end
    @(negedge SCLK);
    cal_init_ack = 1'b0;
    req_w_req    = '0;
    checks++;
    if (req_ack !== 4'b0100 || cal_init_mr_w_req !== 1'b0) begin
      errors++;
      $display("FAIL single_ack: got req_ack=%b w_req=%b, required 0100 0", req_ack, cal_init_mr_w_req);
    end
    @(negedge SCLK);
    checks++;
    if (req_ack !== 4'b0000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_release: got req_ack=%b busy=%b, required 0000 1", req_ack, busy);
    end
    @(negedge SCLK);
    checks++;
    if (busy !== 1'b0 || grant_id !== 3'd2 || cal_init_mr_addr !== 8'h06) begin
      errors++;
      $display("FAIL single_done: got busy=%b grant_id=%0d addr=%h, required 0 2 06",
               busy, grant_id, cal_init_mr_addr);
    end
  endtask

  task automatic test_payload_stable;
    int n;
    sb_q.push_back(mk_exp(0, 8'h2A, 18'h00080, 18'h00FFF, 2'b10));
    drive_req(0, 8'h2A, 18'h00080, 18'h00FFF, 2'b10);
    req_w_req = 4'b0001;
    n = 0;
    while (!cal_init_mr_w_req && n < 20) begin
      @(negedge SCLK);
      n++;
    end
    repeat (2) @(negedge SCLK);
    drive_req(0, 8'h2A, 18'h00099, 18'h00FFF, 2'b10);
    repeat (2) @(negedge SCLK);
    checks++;
    if (cal_init_mr_w_req !== 1'b1 || cal_init_mr_wr_data !== 18'h00080) begin
      errors++;
      $display("FAIL payload_frozen: got w_req=%b data=%h, required 1 00080", cal_init_mr_w_req, cal_init_mr_wr_data);
    end
    cal_init_ack = 1'b1;
    @(negedge SCLK);
    cal_init_ack = 1'b0;
    req_w_req    = '0;
    checks++;
    if (req_ack !== 4'b0001 || cal_init_mr_wr_data !== 18'h00080) begin
      errors++;
      $display("FAIL payload_ack: got req_ack=%b data=%h, required 0001 00080", req_ack, cal_init_mr_wr_data);
    end
    repeat (3) @(negedge SCLK);
  endtask

  task automatic test_spurious;
    checks++;
    if (spurious_ack !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL spurious_pre: got spurious_ack=%b busy=%b, required 0 0", spurious_ack, busy);
    end
    cal_init_ack = 1'b1;
    @(negedge SCLK);
    cal_init_ack = 1'b0;
    checks++;
    if (spurious_ack !== 1'b1 || req_ack !== 4'b0000 || busy !== 1'b0 ||
        cal_init_mr_w_req !== 1'b0 || grant_id !== 3'd0) begin
      errors++;
      $display("FAIL spurious_idle: got spur=%b req_ack=%b busy=%b w_req=%b grant_id=%0d, required 1 0000 0 0 0",
               spurious_ack, req_ack, busy, cal_init_mr_w_req, grant_id);
    end
    repeat (2) @(negedge SCLK);
    checks++;
    if (spurious_ack !== 1'b1 || req_ack !== 4'b0000) begin
      errors++;
      $display("FAIL spurious_sticky: got spur=%b req_ack=%b, required 1 0000", spurious_ack, req_ack);
    end
  endtask

  task automatic test_watchdog;
    int n;
    do_reset();
    // Ack on the expiry cycle: normal completion, no timeout flag.
    sb_q.push_back(mk_exp(3, 8'h0B, 18'h12345, 18'h3C3C3, 2'b11));
    drive_req(3, 8'h0B, 18'h12345, 18'h3C3C3, 2'b11);
    req_w_req = 4'b1000;
    n = 0;
    while (!cal_init_mr_w_req && n < 20) begin
      @(negedge SCLK);
      n++;
    end
    repeat (15) @(negedge SCLK);
    checks++;
    if (cal_init_mr_w_req !== 1'b1 || req_ack !== 4'b0000) begin
      errors++;
      $display("FAIL wd_same_pre: got w_req=%b req_ack=%b, required 1 0000", cal_init_mr_w_req, req_ack);
    end
    cal_init_ack = 1'b1;
    @(negedge SCLK);
    cal_init_ack = 1'b0;
    req_w_req    = '0;
    checks++;
    if (req_ack !== 4'b1000 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL wd_same_cycle: got req_ack=%b timeout_err=%b, required 1000 0", req_ack, timeout_err);
    end
    repeat (3) @(negedge SCLK);
    // No ack at all: forced release after 16 cycles in ISSUE.
    sb_q.push_back(mk_exp(3, 8'h0B, 18'h12345, 18'h3C3C3, 2'b11));
    req_w_req = 4'b1000;
    n = 0;
    while (!cal_init_mr_w_req && n < 20) begin
      @(negedge SCLK);
      n++;
    end
    repeat (15) @(negedge SCLK);
    checks++;
    if (cal_init_mr_w_req !== 1'b1 || req_ack !== 4'b0000 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL wd_pre: got w_req=%b req_ack=%b timeout_err=%b, required 1 0000 0",
               cal_init_mr_w_req, req_ack, timeout_err);
    end
    @(negedge SCLK);
    req_w_req = '0;
    checks++;
    if (req_ack !== 4'b1000 || timeout_err !== 1'b1 || cal_init_mr_w_req !== 1'b0) begin
      errors++;
      $display("FAIL wd_expire: got req_ack=%b timeout_err=%b w_req=%b, required 1000 1 0",
               req_ack, timeout_err, cal_init_mr_w_req);
    end
    @(negedge SCLK);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL wd_release: got busy=%b, required 1", busy);
    end
    @(negedge SCLK);
    checks++;
    if (busy !== 1'b0 || timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL wd_idle: got busy=%b timeout_err=%b, required 0 1", busy, timeout_err);
    end
  endtask

  task automatic test_reset_mid_issue;
    int n;
    // Complete one grant of requester 1 so the pointer moves to 2.
    sb_q.push_back(mk_exp(1, 8'h33, 18'h0AAAA, 18'h15555, 2'b10));
    drive_req(1, 8'h33, 18'h0AAAA, 18'h15555, 2'b10);
    req_w_req = 4'b0010;
    n = 0;
    while (!cal_init_mr_w_req && n < 20) begin
      @(negedge SCLK);
      n++;
    end
    @(negedge SCLK);
    cal_init_ack = 1'b1;
    @(negedge SCLK);
    cal_init_ack = 1'b0;
    req_w_req    = '0;
    checks++;
    if (req_ack !== 4'b0010) begin
      errors++;
      $display("FAIL rst_pre_ack: got %b, required 0010", req_ack);
    end
    repeat (3) @(negedge SCLK);
    sb_q.push_back(mk_exp(1, 8'h33, 18'h0AAAA, 18'h15555, 2'b10));
    req_w_req = 4'b0010;
    n = 0;
    while (!cal_init_mr_w_req && n < 20) begin
      @(negedge SCLK);
      n++;
    end
    @(negedge SCLK);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (all_outs !== '0) begin
      errors++;
      $display("FAIL rst_async: got %h, required 0", all_outs);
    end
    drive_req(3, 8'h44, 18'h3FFFF, 18'h00001, 2'b01);
    req_w_req = 4'b1010;
    sb_q.push_back(mk_exp(1, 8'h33, 18'h0AAAA, 18'h15555, 2'b10));
    sb_q.push_back(mk_exp(3, 8'h44, 18'h3FFFF, 18'h00001, 2'b01));
    repeat (2) @(negedge SCLK);
    checks++;
    if (all_outs !== '0) begin
      errors++;
      $display("FAIL rst_hold: got %h, required 0", all_outs);
    end
    reset_n = 1'b1;
    n = 0;
    while (!cal_init_mr_w_req && n < 20) begin
      @(negedge SCLK);
      n++;
    end
    checks++;
    if (cal_init_mr_w_req !== 1'b1 || grant_id !== 3'd1) begin
      errors++;
      $display("FAIL rst_ptr: got w_req=%b grant_id=%0d, required 1 1", cal_init_mr_w_req, grant_id);
    end
    @(negedge SCLK);
    cal_init_ack = 1'b1;
    @(negedge SCLK);
    cal_init_ack = 1'b0;
    req_w_req    = 4'b1000;
    n = 0;
    while (!cal_init_mr_w_req && n < 20) begin
      @(negedge SCLK);
      n++;
    end
    checks++;
    if (cal_init_mr_w_req !== 1'b1 || grant_id !== 3'd3) begin
      errors++;
      $display("FAIL rst_second: got w_req=%b grant_id=%0d, required 1 3", cal_init_mr_w_req, grant_id);
    end
    @(negedge SCLK);
    cal_init_ack = 1'b1;
    @(negedge SCLK);
    cal_init_ack = 1'b0;
    req_w_req    = '0;
    repeat (3) @(negedge SCLK);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish before 200us");
    $fatal(1, "bench timed out");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_payload_stable();
    test_spurious();
    test_watchdog();
    test_reset_mid_issue();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending grants, required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
